// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo family: read-data timing encodings,
// default word width and pointer sizing helpers.
package fifo_pkg;

  // How the upstream FIFO presents rd_data relative to rd_en.
  localparam int RD_SHOWAHEAD  = 0;  // data valid in the same cycle as rd_en
  localparam int RD_REGISTERED = 1;  // data valid one cycle after rd_en

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Bits needed to index 0..depth-1; never less than one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Bits needed to hold an occupancy count of 0..depth.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular holding buffer between the FIFO read port and the stream
// output. Head entry is presented straight from storage, so the output word
// is always registered and never passes combinationally from push_data.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 2,
  localparam int PW        = ptr_width(DEPTH),
  localparam int OW        = occ_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OW-1:0]         occ
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Storage write at the tail; cleared on reset so the output word reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[tail] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the buffer and realigns
  // both pointers so later pushes land where the head will look.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= wrap_inc(tail);
      if (pop)  head <= wrap_inc(head);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;  // idle, or push+pop leaves count unchanged
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for sync_fifo: issues rd_en only when there is room
// for the word (counting a read still in flight), captures rd_data at the
// FIFO's read latency and re-presents words as a valid/ready stream.
// SKID_DEPTH is expected to be 2..4; 2 is the minimum for full throughput
// with a registered-read FIFO.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int RDATA_MODE = RD_REGISTERED,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  busy
);

  localparam int            OW        = occ_width(SKID_DEPTH);
  localparam logic [OW:0]   DEPTH_LIM = (OW + 1)'(SKID_DEPTH);

  logic [OW-1:0] occ;
  logic          inflight;
  logic          push;
  logic          pop;
  logic [OW:0]   demand;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;

  // Slots that will be committed after this edge if no new read is issued.
  // pop implies occ >= 1, so the subtraction cannot go negative.
  assign demand = {1'b0, occ} + (OW + 1)'(inflight) - (OW + 1)'(pop);

  // Read only when the FIFO has data and the word is guaranteed a slot;
  // this is what makes both FIFO underflow and buffer overflow impossible.
  assign fifo_rd_en = !rst && !flush && !fifo_empty && (demand < DEPTH_LIM);

  if (RDATA_MODE == RD_REGISTERED) begin : g_registered
    // One outstanding read: data returns the cycle after rd_en and is
    // dropped if flush is high when it arrives.
    always_ff @(posedge clk) begin
      if (rst || flush) inflight <= 1'b0;
      else              inflight <= fifo_rd_en;
    end
    assign push = inflight && !flush;
  end else begin : g_showahead
    // Data is already on the bus when rd_en is raised.
    assign inflight = 1'b0;
    assign push     = fifo_rd_en;
  end

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (SKID_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_data(fifo_rd_data),
    .pop      (pop),
    .head_data(m_data),
    .occ      (occ)
  );

  // Delivered-beat counter; flush does not touch it, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)      beat_cnt <= '0;
    else if (pop) beat_cnt <= beat_cnt + 1'b1;
  end

  assign busy = (occ != '0) || inflight;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: three instances (show-ahead depth 2, registered
// depth 2, registered depth 4), each fed by a behavioural sync_fifo model.
// Words leaving the FIFO go into a per-instance expectation queue; a monitor
// pops it on every accepted beat. Flush/reset discard everything already
// handed out by the FIFO but not yet delivered.
module tb_fifo_rd_stream;
  localparam int NI    = 3;
  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int MEMSZ = 4096;

  function automatic int mode_of(input int g);
    return (g == 0) ? 0 : 1;
  endfunction
  function automatic int depth_of(input int g);
    return (g == 2) ? 4 : 2;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst, flush, m_ready, fifo_empty, fifo_rd_en, m_valid, busy;
  logic [DW-1:0] fifo_rd_data [NI];
  logic [DW-1:0] m_data       [NI];
  logic [CW-1:0] beat_cnt     [NI];

  bit [DW-1:0] mem    [NI][MEMSZ];
  int          wr_ptr [NI];
  bit          mon_en = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input bit ok, input string name, input int g,
                     input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h want %0h", name, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    fifo_rd_stream #(
      .DATA_WIDTH(DW), .RDATA_MODE(mode_of(g)),
      .SKID_DEPTH(depth_of(g)), .CNT_WIDTH(CW)
    ) dut (
      .clk(clk), .rst(rst[g]), .fifo_empty(fifo_empty[g]),
      .fifo_rd_data(fifo_rd_data[g]), .fifo_rd_en(fifo_rd_en[g]),
      .flush(flush[g]), .m_valid(m_valid[g]), .m_data(m_data[g]),
      .m_ready(m_ready[g]), .beat_cnt(beat_cnt[g]), .busy(busy[g])
    );

    // sync_fifo model: array plus read pointer; never reset by the DUT
    int            rd_ptr = 0;
    logic [DW-1:0] exp_q [$];
    assign fifo_empty[g] = (rd_ptr == wr_ptr[g]);

    if (mode_of(g) == 0) begin : g_sa
      assign fifo_rd_data[g] = mem[g][rd_ptr];
    end else begin : g_rg
      logic [DW-1:0] rdata_q = '0;
      always @(posedge clk)
        if (fifo_rd_en[g] && !fifo_empty[g]) rdata_q <= mem[g][rd_ptr];
      assign fifo_rd_data[g] = rdata_q;
    end

    always @(posedge clk) begin
      if (fifo_rd_en[g] && !fifo_empty[g]) begin
        exp_q.push_back(mem[g][rd_ptr]);
        rd_ptr <= rd_ptr + 1;
      end
    end

    // Monitor: sampled mid-cycle, all effects of the coming edge applied last
    logic [CW-1:0] cnt_m     = '0;
    bit            hold_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;
    bit            wrap_seen = 1'b0;

    always @(negedge clk) begin : mon
      logic [DW-1:0] w;
      if (mon_en) begin
        chk(beat_cnt[g] == cnt_m, "beat_cnt", g, beat_cnt[g], cnt_m);
        chk(busy[g] == (exp_q.size() != 0), "busy", g, busy[g], exp_q.size() != 0);
        chk(!(fifo_rd_en[g] && fifo_empty[g]), "underflow", g, fifo_rd_en[g], 0);
        chk(exp_q.size() <= depth_of(g), "occupancy", g, exp_q.size(), depth_of(g));
        if (hold_prev)
          chk(m_valid[g] && m_data[g] == data_prev, "hold_stable", g, m_data[g], data_prev);
        if (m_valid[g] && m_ready[g]) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "extra_beat", g, m_data[g], 0);
          end else begin
            w = exp_q.pop_front();
            chk(m_data[g] == w, "data", g, m_data[g], w);
          end
        end
        hold_prev = m_valid[g] && !m_ready[g] && !flush[g] && !rst[g];
        data_prev = m_data[g];
        if (rst[g]) cnt_m = '0;
        else if (m_valid[g] && m_ready[g]) begin
          if (cnt_m == '1) wrap_seen = 1'b1;
          cnt_m = cnt_m + 1'b1;
        end
        if (rst[g] || flush[g]) exp_q.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int m, input logic [DW-1:0] d);
    mem[m][wr_ptr[m]] = d;
    wr_ptr[m]++;
  endtask

  int  first_re, first_mv, last_re, last_mv, n_re, n_mv, base;
  bit  found, done;
  logic [DW-1:0] nxt;

  initial begin
    rst = '1; flush = '0; m_ready = '0;
    for (int i = 0; i < NI; i++) wr_ptr[i] = 0;
    repeat (2) step();
    @(negedge clk);
    for (int m = 0; m < NI; m++) begin
      chk(m_valid[m] == 1'b0, "rst_valid", m, m_valid[m], 0);
      chk(m_data[m] == '0, "rst_data", m, m_data[m], 0);
      chk(beat_cnt[m] == '0, "rst_cnt", m, beat_cnt[m], 0);
      chk(busy[m] == 1'b0, "rst_busy", m, busy[m], 0);
      chk(fifo_rd_en[m] == 1'b0, "rst_rd_en", m, fifo_rd_en[m], 0);
    end
    step();
    rst = '0;
    mon_en = 1'b1;

    // 1: registered mode, four preloaded words, consumer always ready
    m_ready[1] = 1'b1;
    load(1, 8'hA5); load(1, 8'hA6); load(1, 8'hA7); load(1, 8'hA8);
    first_re = -1; first_mv = -1; n_re = 0; n_mv = 0; last_re = 0; last_mv = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (fifo_rd_en[1]) begin if (first_re < 0) first_re = k; n_re++; last_re = k; end
      if (m_valid[1])    begin if (first_mv < 0) first_mv = k; n_mv++; last_mv = k; end
    end
    chk(n_re == 4 && last_re - first_re == 3, "t1_rd_en_run", 1, n_re, 4);
    chk(first_mv - first_re == 2, "t1_latency", 1, first_mv - first_re, 2);
    chk(n_mv == 4 && last_mv - first_mv == 3, "t1_beats", 1, n_mv, 4);
    chk(beat_cnt[1] == 8'd4, "t1_cnt", 1, beat_cnt[1], 4);
    chk(busy[1] == 1'b0, "t1_idle", 1, busy[1], 0);

    // 2: backpressure for ten cycles, reads stop at two outstanding words
    step();
    m_ready[1] = 1'b0;
    load(1, 8'hA5); load(1, 8'hA6); load(1, 8'hA7); load(1, 8'hA8);
    n_re = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (fifo_rd_en[1]) n_re++;
      if (k == 9) chk(m_valid[1] && m_data[1] == 8'hA5, "t2_hold_a5", 1, m_data[1], 8'hA5);
    end
    chk(n_re == 2, "t2_rd_stop", 1, n_re, 2);
    step();
    m_ready[1] = 1'b1;
    repeat (10) @(negedge clk);
    chk(beat_cnt[1] == 8'd8, "t2_cnt", 1, beat_cnt[1], 8);

    // 3: empty FIFO, nothing is read or emitted
    n_re = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fifo_rd_en[1] || m_valid[1]) n_re++;
    end
    chk(n_re == 0, "t3_idle", 1, n_re, 0);

    // 4: flush with two buffered words and one in flight (depth-4 instance)
    step();
    m_ready[2] = 1'b0;
    load(2, 8'hB1); load(2, 8'hB2); load(2, 8'hB3);
    repeat (3) step();
    flush[2] = 1'b1;
    @(negedge clk);
    chk(busy[2] == 1'b1, "t4_busy_before", 2, busy[2], 1);
    chk(fifo_rd_en[2] == 1'b0, "t4_rd_en_flush", 2, fifo_rd_en[2], 0);
    step();
    flush[2] = 1'b0;
    @(negedge clk);
    chk(m_valid[2] == 1'b0, "t4_valid_after", 2, m_valid[2], 0);
    chk(busy[2] == 1'b0, "t4_busy_after", 2, busy[2], 0);
    step();
    load(2, 8'hC1); load(2, 8'hC2);
    m_ready[2] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (m_valid[2]) begin
        found = 1'b1;
        chk(m_data[2] == 8'hC1, "t4_resume", 2, m_data[2], 8'hC1);
      end
    end
    if (!found) chk(1'b0, "t4_resume_timeout", 2, 0, 1);
    repeat (6) @(negedge clk);
    chk(beat_cnt[2] == 8'd2, "t4_cnt", 2, beat_cnt[2], 2);

    // 5: reset pulse after two of the beats
    step();
    base = beat_cnt[1];
    for (int i = 0; i < 6; i++) load(1, 8'hD1 + 8'(i));
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (beat_cnt[1] == 8'(base + 2)) found = 1'b1;
    end
    if (!found) chk(1'b0, "t5_wait_timeout", 1, beat_cnt[1], base + 2);
    step();
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    @(negedge clk);
    chk(m_valid[1] == 1'b0, "t5_valid", 1, m_valid[1], 0);
    chk(m_data[1] == '0, "t5_data", 1, m_data[1], 0);
    chk(beat_cnt[1] == '0, "t5_cnt", 1, beat_cnt[1], 0);
    chk(busy[1] == 1'b0, "t5_busy", 1, busy[1], 0);
    nxt = mem[1][g_inst[1].rd_ptr];
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (m_valid[1]) begin
        found = 1'b1;
        chk(m_data[1] == nxt, "t5_next_unread", 1, m_data[1], nxt);
      end
    end
    if (!found) chk(1'b0, "t5_resume_timeout", 1, 0, 1);
    repeat (6) @(negedge clk);

    // 6: show-ahead mode, eight words, ready toggling every cycle
    step();
    for (int i = 0; i < 8; i++) load(0, 8'hE0 + 8'(i));
    m_ready[0] = 1'b1;
    n_mv = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0) chk(fifo_rd_en[0] && !m_valid[0], "t6_issue", 0, m_valid[0], 0);
      if (k == 1) chk(m_valid[0] == 1'b1, "t6_latency", 0, m_valid[0], 1);
      if (m_valid[0] && m_ready[0]) n_mv++;
      step();
      m_ready[0] = !m_ready[0];
    end
    chk(n_mv == 8, "t6_beats", 0, n_mv, 8);
    chk(beat_cnt[0] == 8'd8, "t6_cnt", 0, beat_cnt[0], 8);

    // Random traffic on all instances; enough beats on inst0 to wrap beat_cnt
    for (int c = 0; c < 1000; c++) begin
      for (int m = 0; m < NI; m++) begin
        if ($urandom_range(3) != 0) load(m, 8'($urandom));
        m_ready[m] = ($urandom_range(3) != 0);
        flush[m]   = ($urandom_range(49) == 0);
        rst[m]     = (m != 0) && ($urandom_range(199) == 0);
      end
      step();
    end
    flush = '0; rst = '0; m_ready = '1;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      done = (busy == '0) && (fifo_empty == '1);
    end
    chk(done, "drain", 0, busy, 0);
    chk(g_inst[0].wrap_seen, "cnt_wrap", 0, g_inst[0].wrap_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
